// File: rtl/injection_ignition_scheduler_pkg.sv
// Shared stroke encodings and default widths for the EFI timing blocks.
package injection_ignition_scheduler_pkg;

  localparam int DEFAULT_TICK_W  = 5;
  localparam int DEFAULT_WIDTH_W = 20;

  typedef enum logic [1:0] {
    STROKE_INTAKE      = 2'b00,
    STROKE_COMPRESSION = 2'b01,
    STROKE_COMBUSTION  = 2'b10,
    STROKE_EXHAUST     = 2'b11
  } stroke_t;

endpackage

// File: rtl/injection_ignition_scheduler_counter.sv
// Loadable down counter; terminal marks the last cycle of a loaded run.
module pulse_down_counter #(
  parameter int WIDTH_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic [WIDTH_W-1:0] load_value,
  output logic               terminal
);

  logic [WIDTH_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (load)
      count_reg <= load_value;
    else if (dec && count_reg != '0)
      count_reg <= count_reg - WIDTH_W'(1);
  end

  assign terminal = (count_reg == WIDTH_W'(1));

endmodule

// File: rtl/injection_ignition_scheduler.sv
// Per-cylinder injector pulse and coil dwell/spark placement driven by
// the stroke tracker and crank ticks.
module injection_ignition_scheduler
  import injection_ignition_scheduler_pkg::*;
#(
  parameter int                 TICK_W    = DEFAULT_TICK_W,
  parameter int                 WIDTH_W   = DEFAULT_WIDTH_W,
  parameter logic [WIDTH_W-1:0] MAX_DWELL = 20'd400000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               on,
  input  logic               crank_tick,
  input  logic [1:0]         stroke,
  input  logic               allow_injection,
  input  logic               allow_ignition,
  input  logic [TICK_W-1:0]  inj_start_tick,
  input  logic [WIDTH_W-1:0] inj_width,
  input  logic [TICK_W-1:0]  dwell_tick,
  input  logic [TICK_W-1:0]  spark_tick,
  output logic               injector_out,
  output logic               coil_out,
  output logic               spark_pulse,
  output logic               inj_overrun,
  output logic               dwell_timeout
);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_ON, I_DONE} inj_state_t;
  typedef enum logic [1:0] {G_IDLE, G_WAIT, G_DWELL, G_FIRE} ign_state_t;

  localparam logic [TICK_W-1:0] TICK_MAX = '1;

  logic [1:0]         stroke_q;
  logic [TICK_W-1:0]  tick_idx_reg;
  logic [TICK_W-1:0]  cur_tick;
  logic               entry;
  logic [TICK_W-1:0]  start_latched_reg, dwell_latched_reg, spark_latched_reg;
  logic [WIDTH_W-1:0] width_latched_reg;
  inj_state_t         inj_state_reg, inj_state_next;
  ign_state_t         ign_state_reg, ign_state_next;
  logic               inj_latch, inj_load, inj_terminal, overrun_set;
  logic               ign_latch, dwell_load, dwell_terminal, timeout_set;
  logic               injector_next, coil_next, spark_next, overrun_next, timeout_next;

  assign entry = (stroke != stroke_q);
  // The entry cycle already sees index 0, so a stale count never matches.
  assign cur_tick = entry ? '0 : tick_idx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stroke_q          <= STROKE_INTAKE;
      tick_idx_reg      <= '0;
      start_latched_reg <= '0;
      width_latched_reg <= '0;
      dwell_latched_reg <= '0;
      spark_latched_reg <= '0;
      inj_state_reg     <= I_IDLE;
      ign_state_reg     <= G_IDLE;
    end else begin
      stroke_q      <= stroke;
      inj_state_reg <= inj_state_next;
      ign_state_reg <= ign_state_next;
      if (!on || entry)
        tick_idx_reg <= '0;
      else if (crank_tick && tick_idx_reg != TICK_MAX)
        tick_idx_reg <= tick_idx_reg + TICK_W'(1);
      if (inj_latch) begin
        start_latched_reg <= inj_start_tick;
        width_latched_reg <= inj_width;
      end
      if (ign_latch) begin
        dwell_latched_reg <= dwell_tick;
        spark_latched_reg <= spark_tick;
      end
    end
  end

  always_comb begin
    inj_state_next = inj_state_reg;
    inj_latch      = 1'b0;
    inj_load       = 1'b0;
    overrun_set    = 1'b0;
    if (!on)
      inj_state_next = I_IDLE;
    else if (entry && stroke == STROKE_INTAKE && allow_injection) begin
      inj_state_next = I_WAIT;
      inj_latch      = 1'b1;
    end else begin
      case (inj_state_reg)
        I_WAIT:
          if (stroke != STROKE_INTAKE)
            inj_state_next = I_DONE;
          else if (cur_tick == start_latched_reg) begin
            if (width_latched_reg == '0)
              inj_state_next = I_DONE;
            else begin
              inj_state_next = I_ON;
              inj_load       = 1'b1;
            end
          end
        I_ON:
          if (stroke != STROKE_INTAKE) begin
            inj_state_next = I_DONE;
            overrun_set    = 1'b1;
          end else if (inj_terminal)
            inj_state_next = I_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    ign_state_next = ign_state_reg;
    ign_latch      = 1'b0;
    dwell_load     = 1'b0;
    timeout_set    = 1'b0;
    if (!on)
      ign_state_next = G_IDLE;
    else if (entry && stroke == STROKE_COMPRESSION) begin
      ign_state_next = G_WAIT;
      ign_latch      = 1'b1;
    end else begin
      case (ign_state_reg)
        G_WAIT:
          if (stroke == STROKE_EXHAUST)
            ign_state_next = G_IDLE;
          else if (stroke == STROKE_COMPRESSION && cur_tick == dwell_latched_reg) begin
            ign_state_next = G_DWELL;
            dwell_load     = 1'b1;
          end
        G_DWELL:
          if (stroke == STROKE_EXHAUST)
            ign_state_next = G_FIRE;
          else if (stroke == STROKE_COMBUSTION && allow_ignition &&
                   cur_tick == spark_latched_reg)
            ign_state_next = G_FIRE;
          else if (dwell_terminal) begin
            ign_state_next = G_FIRE;
            timeout_set    = 1'b1;
          end
        G_FIRE:
          ign_state_next = G_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    injector_next = (inj_state_next == I_ON);
    coil_next     = (ign_state_next == G_DWELL);
    spark_next    = (ign_state_next == G_FIRE);
    overrun_next  = on && (inj_overrun || overrun_set);
    timeout_next  = on && (dwell_timeout || timeout_set);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      injector_out  <= 1'b0;
      coil_out      <= 1'b0;
      spark_pulse   <= 1'b0;
      inj_overrun   <= 1'b0;
      dwell_timeout <= 1'b0;
    end else begin
      injector_out  <= injector_next;
      coil_out      <= coil_next;
      spark_pulse   <= spark_next;
      inj_overrun   <= overrun_next;
      dwell_timeout <= timeout_next;
    end
  end

  pulse_down_counter #(.WIDTH_W(WIDTH_W)) u_inj_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (inj_load),
    .dec        (inj_state_reg == I_ON),
    .load_value (width_latched_reg),
    .terminal   (inj_terminal)
  );

  // Loaded with MAX_DWELL-1 so the forced spark lands on dwell cycle MAX_DWELL.
  pulse_down_counter #(.WIDTH_W(WIDTH_W)) u_dwell_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (dwell_load),
    .dec        (ign_state_reg == G_DWELL),
    .load_value (MAX_DWELL - WIDTH_W'(1)),
    .terminal   (dwell_terminal)
  );

endmodule

// File: tb/tb_injection_ignition_scheduler.sv
// Directed and randomized stroke sequences checked cycle by cycle against a
// counter-based reference of the injection/ignition rules.
module tb_injection_ignition_scheduler;

  localparam int MAXD = 50;

  logic        clk = 1'b0;
  logic        reset, on, crank_tick, allow_injection, allow_ignition;
  logic [1:0]  stroke;
  logic [4:0]  inj_start_tick, dwell_tick, spark_tick;
  logic [19:0] inj_width;
  logic        injector_out, coil_out, spark_pulse, inj_overrun, dwell_timeout;

  injection_ignition_scheduler #(.TICK_W(5), .WIDTH_W(20), .MAX_DWELL(20'd50)) dut (
    .clk             (clk),
    .reset           (reset),
    .on              (on),
    .crank_tick      (crank_tick),
    .stroke          (stroke),
    .allow_injection (allow_injection),
    .allow_ignition  (allow_ignition),
    .inj_start_tick  (inj_start_tick),
    .inj_width       (inj_width),
    .dwell_tick      (dwell_tick),
    .spark_tick      (spark_tick),
    .injector_out    (injector_out),
    .coil_out        (coil_out),
    .spark_pulse     (spark_pulse),
    .inj_overrun     (inj_overrun),
    .dwell_timeout   (dwell_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: ticks counted since stroke change, remaining open cycles,
  // coil age in cycles.
  int m_prev = 0, m_ticks = 0;
  bit m_inj_armed = 0, m_coil_armed = 0;
  int m_start = 0, m_width = 0, m_left = 0;
  int m_dwell_at = 0, m_spark_at = 0, m_age = 0;
  bit m_spark = 0, m_overrun = 0, m_timeout = 0;

  int hi_inj, hi_coil, n_spark, first_rise;

  task automatic model_step();
    bit new_stroke;
    bit fire;
    int t_now;
    new_stroke = (int'(stroke) != m_prev);
    t_now      = new_stroke ? 0 : m_ticks;
    fire       = 0;
    m_spark    = 0;
    if (!on) begin
      m_inj_armed = 0; m_left = 0; m_coil_armed = 0; m_age = 0;
      m_overrun = 0; m_timeout = 0;
    end else begin
      if (new_stroke && stroke == 2'd0 && allow_injection) begin
        m_inj_armed = 1; m_start = int'(inj_start_tick); m_width = int'(inj_width); m_left = 0;
      end else if (stroke != 2'd0) begin
        if (m_left > 0) m_overrun = 1;
        m_inj_armed = 0; m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_inj_armed && t_now == m_start) begin
        m_inj_armed = 0; m_left = m_width;
      end

      if (new_stroke && stroke == 2'd1) begin
        m_coil_armed = 1; m_dwell_at = int'(dwell_tick); m_spark_at = int'(spark_tick); m_age = 0;
      end else if (m_age > 0) begin
        if (stroke == 2'd3 || (stroke == 2'd2 && allow_ignition && t_now == m_spark_at))
          fire = 1;
        else if (m_age == MAXD - 1) begin
          fire = 1; m_timeout = 1;
        end else
          m_age++;
        if (fire) begin m_age = 0; m_spark = 1; end
      end else if (m_coil_armed) begin
        if (stroke == 2'd3)
          m_coil_armed = 0;
        else if (stroke == 2'd1 && t_now == m_dwell_at) begin
          m_coil_armed = 0; m_age = 1;
        end
      end
    end
    if (!on || new_stroke) m_ticks = 0;
    else if (crank_tick && m_ticks < 31) m_ticks++;
    m_prev = int'(stroke);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("injector_out", injector_out, m_left > 0);
    check("coil_out", coil_out, m_age > 0);
    check("spark_pulse", spark_pulse, m_spark);
    check("inj_overrun", inj_overrun, m_overrun);
    check("dwell_timeout", dwell_timeout, m_timeout);
  endtask

  task automatic cycle(input bit tick, input int idx);
    crank_tick = tick;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (injector_out) begin
      hi_inj++;
      if (first_rise < 0) first_rise = idx;
    end
    if (coil_out) hi_coil++;
    if (spark_pulse) n_spark++;
  endtask

  // period 0 = no ticks; rnd adds random ticks, config churn and enable drops.
  task automatic run_stroke(input logic [1:0] s, input int n, input int period,
                            input bit tick_at_entry, input bit rnd);
    bit t;
    stroke = s;
    hi_inj = 0; hi_coil = 0; n_spark = 0; first_rise = -1;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        t = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 15) == 0) begin
          inj_start_tick = 5'($urandom_range(0, 6));
          inj_width      = 20'($urandom_range(0, 40));
          dwell_tick     = 5'($urandom_range(0, 6));
          spark_tick     = 5'($urandom_range(0, 6));
        end
        if (on && $urandom_range(0, 199) == 0) on = 1'b0;
        else if (!on && $urandom_range(0, 7) == 0) on = 1'b1;
      end else
        t = (period > 0 && (i % period) == period - 1) || (i == 0 && tick_at_entry);
      cycle(t, i);
    end
    crank_tick = 1'b0;
    $display("stroke %0d: %0d clk inj_hi=%0d first_rise=%0d coil_hi=%0d sparks=%0d ovr=%0b tmo=%0b",
             s, n, hi_inj, first_rise, hi_coil, n_spark, inj_overrun, dwell_timeout);
  endtask

  initial begin
    reset = 1'b1; on = 1'b0; crank_tick = 1'b0; stroke = 2'd3;
    allow_injection = 1'b1; allow_ignition = 1'b1;
    inj_start_tick = 5'd2; inj_width = 20'd15; dwell_tick = 5'd8; spark_tick = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Injector window after the 2nd intake tick, then dwell/spark in order.
    on = 1'b1;
    run_stroke(2'd3, 20, 10, 0, 0);
    run_stroke(2'd0, 60, 10, 0, 0);
    check_int("inj_rise_step", first_rise, 20);
    check_int("inj_high_cycles", hi_inj, 15);
    run_stroke(2'd1, 90, 10, 0, 0);
    check_int("comp_coil_cycles", hi_coil, 10);
    run_stroke(2'd2, 30, 10, 0, 0);
    check_int("comb_coil_cycles", hi_coil, 10);
    check_int("comb_sparks", n_spark, 1);
    check("no_timeout", dwell_timeout, 1'b0);
    run_stroke(2'd3, 20, 10, 0, 0);

    // Truncated injector, then dwell without ticks until the forced spark.
    inj_start_tick = 5'd1; inj_width = 20'd500; dwell_tick = 5'd0;
    run_stroke(2'd0, 60, 10, 0, 0);
    check_int("ovr_rise_step", first_rise, 10);
    run_stroke(2'd1, 70, 0, 0, 0);
    check_int("ovr_inj_after", hi_inj, 0);
    check("ovr_sticky", inj_overrun, 1'b1);
    check_int("tmo_coil_cycles", hi_coil, MAXD - 1);
    check_int("tmo_sparks", n_spark, 1);
    check("tmo_flag", dwell_timeout, 1'b1);
    run_stroke(2'd2, 10, 0, 0, 0);
    run_stroke(2'd3, 10, 0, 0, 0);

    // Enable dropped with injector open and coil dwelling.
    inj_start_tick = 5'd0;
    run_stroke(2'd1, 10, 0, 0, 0);
    run_stroke(2'd0, 5, 0, 0, 0);
    check("pre_off_coil", coil_out, 1'b1);
    check("pre_off_inj", injector_out, 1'b1);
    on = 1'b0;
    run_stroke(2'd0, 3, 0, 0, 0);
    check_int("off_inj", hi_inj, 0);
    check_int("off_coil", hi_coil, 0);
    check_int("off_spark", n_spark, 0);
    check("off_ovr", inj_overrun, 1'b0);
    check("off_tmo", dwell_timeout, 1'b0);
    on = 1'b1;
    run_stroke(2'd0, 20, 3, 0, 0);
    check_int("reenable_no_inj", hi_inj, 0);
    run_stroke(2'd1, 5, 0, 0, 0);
    check_int("fresh_comp_coil", hi_coil, 4);
    run_stroke(2'd3, 5, 0, 0, 0);
    check_int("exhaust_fire", n_spark, 1);

    // Crank tick coincident with entry must not count.
    inj_start_tick = 5'd1; inj_width = 20'd3;
    run_stroke(2'd0, 20, 5, 1, 0);
    check_int("coinc_rise_step", first_rise, 5);
    check_int("coinc_high", hi_inj, 3);
    run_stroke(2'd3, 5, 0, 0, 0);
    inj_start_tick = 5'd0; inj_width = 20'd0;
    run_stroke(2'd0, 20, 5, 1, 0);
    check_int("zero_width_high", hi_inj, 0);
    run_stroke(2'd1, 5, 0, 0, 0);

    // Random stroke sequences with occasional skips and config churn.
    for (int k = 0; k < 40; k++) begin
      logic [1:0] nxt;
      nxt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : stroke + 2'd1;
      allow_injection = ($urandom_range(0, 3) != 0);
      allow_ignition  = ($urandom_range(0, 3) != 0);
      run_stroke(nxt, $urandom_range(3, 60), 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
